// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit
// ----------------
// HI/LO multiply/divide unit for the EX stage. It owns the HI and LO
// registers and performs MULT/MULTU (fixed-latency countdown), DIV/DIVU
// (radix-2 restoring divider, one quotient bit per edge) and MTHI/MTLO.
// All state updates happen on the falling edge of Clock, matching the
// register file. Reset is asynchronous and active low.
//
// Build option: define HILO_ACCUM_EN to implement MADD/MADDU/MSUB/MSUBU
// (Op 7-10). Without it those opcodes behave as reserved and no
// accumulate adder is built.
//
// Ports:
//   Clock      in   clock (falling-edge active)
//   Reset      in   asynchronous active-low reset
//   Start      in   request, sampled only while Busy=0
//   Op[3:0]    in   0 NOP,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MTHI,6 MTLO,
//                   7 MADD,8 MADDU,9 MSUB,10 MSUBU, 11-15 reserved
//   OperandA   in   rs / dividend / MTHI-MTLO source
//   OperandB   in   rt / divisor
//   Busy       out  operation in progress, Start ignored
//   Done       out  one-cycle pulse after a MULT/DIV-class result
//   DivByZero  out  pulses with Done for a divide by zero
//   Hi, Lo     out  HI and LO registers
module hilo_muldiv_unit #(
    parameter int DATA_WIDTH  = 32,
    parameter int MUL_LATENCY = 2
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic [3:0]            Op,
    input  logic [DATA_WIDTH-1:0] OperandA,
    input  logic [DATA_WIDTH-1:0] OperandB,
    output logic                  Busy,
    output logic                  Done,
    output logic                  DivByZero,
    output logic [DATA_WIDTH-1:0] Hi,
    output logic [DATA_WIDTH-1:0] Lo
);

    localparam int DW = DATA_WIDTH;
    // Wide enough for both the divide iteration index and the multiply countdown.
    localparam int CW = $clog2(DW + 16);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef HILO_ACCUM_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   count_reg, count_next;
    logic [DW-1:0]   hi_reg, hi_next;
    logic [DW-1:0]   lo_reg, lo_next;
    // a_reg: multiplicand, or dividend magnitude shifting into quotient bits.
    // b_reg: multiplier, or divisor magnitude.
    logic [DW-1:0]   a_reg, a_next;
    logic [DW-1:0]   b_reg, b_next;
    logic [DW-1:0]   rem_reg, rem_next;
    logic            sgn_reg, sgn_next;     // signed multiply
    logic            qneg_reg, qneg_next;   // negate quotient at commit
    logic            rneg_reg, rneg_next;   // negate remainder at commit
    logic            dbz_reg, dbz_next;
`ifdef HILO_ACCUM_EN
    logic            acc_reg, acc_next;     // accumulate into {Hi,Lo}
    logic            sub_reg, sub_next;     // subtract instead of add
`endif

    // Multiplier: operands extended to 2*DW, result taken modulo 2^(2*DW),
    // which is the correct two's-complement product for the signed case.
    logic [2*DW-1:0] ext_a, ext_b, product, mul_result;
    assign ext_a   = sgn_reg ? {{DW{a_reg[DW-1]}}, a_reg} : {{DW{1'b0}}, a_reg};
    assign ext_b   = sgn_reg ? {{DW{b_reg[DW-1]}}, b_reg} : {{DW{1'b0}}, b_reg};
    assign product = ext_a * ext_b;
`ifdef HILO_ACCUM_EN
    // {Hi,Lo} cannot change while Busy, so the live value equals the one at accept.
    assign mul_result = !acc_reg ? product
                      : (sub_reg ? ({hi_reg, lo_reg} - product) : ({hi_reg, lo_reg} + product));
`else
    assign mul_result = product;
`endif

    // One restoring-division step: shift the next dividend bit into the
    // partial remainder and subtract the divisor if it fits.
    logic [DW:0]   div_shift, div_diff;
    logic          div_fit;
    logic [DW-1:0] rem_step, quo_step, quo_final, rem_final;
    assign div_shift = {rem_reg, a_reg[DW-1]};
    assign div_diff  = div_shift - {1'b0, b_reg};
    assign div_fit   = ~div_diff[DW];
    assign rem_step  = div_fit ? div_diff[DW-1:0] : div_shift[DW-1:0];
    assign quo_step  = {a_reg[DW-2:0], div_fit};
    // Most-negative / -1 falls out naturally: magnitude quotient is 2^(DW-1), not negated.
    assign quo_final = qneg_reg ? (~quo_step + 1'b1) : quo_step;
    assign rem_final = rneg_reg ? (~rem_step + 1'b1) : rem_step;

    logic          accept, div_signed;
    logic [DW-1:0] abs_a, abs_b;
    assign Busy       = (state_reg == S_MUL) || (state_reg == S_DIV);
    assign accept     = Start && !Busy;
    assign div_signed = (Op == OP_DIV);
    assign abs_a      = (div_signed && OperandA[DW-1]) ? (~OperandA + 1'b1) : OperandA;
    assign abs_b      = (div_signed && OperandB[DW-1]) ? (~OperandB + 1'b1) : OperandB;

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        hi_next    = hi_reg;
        lo_next    = lo_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        rem_next   = rem_reg;
        sgn_next   = sgn_reg;
        qneg_next  = qneg_reg;
        rneg_next  = rneg_reg;
        dbz_next   = dbz_reg;
`ifdef HILO_ACCUM_EN
        acc_next   = acc_reg;
        sub_next   = sub_reg;
`endif
        case (state_reg)
            S_MUL: begin
                if (count_reg == CW'(1)) begin
                    {hi_next, lo_next} = mul_result;
                    count_next = '0;
                    state_next = S_FIN;
                end else begin
                    count_next = count_reg - 1'b1;
                end
            end
            S_DIV: begin
                a_next   = quo_step;
                rem_next = rem_step;
                if (count_reg == CW'(DW - 1)) begin
                    lo_next    = quo_final;
                    hi_next    = rem_final;
                    count_next = '0;
                    state_next = S_FIN;
                end else begin
                    count_next = count_reg + 1'b1;
                end
            end
            default: begin
                // IDLE and FIN both return to IDLE unless a new request overrides.
                state_next = S_IDLE;
                dbz_next   = 1'b0;
            end
        endcase

        if (accept) begin
            case (Op)
                OP_MULT, OP_MULTU: begin
                    a_next     = OperandA;
                    b_next     = OperandB;
                    sgn_next   = (Op == OP_MULT);
`ifdef HILO_ACCUM_EN
                    acc_next   = 1'b0;
                    sub_next   = 1'b0;
`endif
                    count_next = CW'(MUL_LATENCY);
                    state_next = S_MUL;
                end
`ifdef HILO_ACCUM_EN
                OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                    a_next     = OperandA;
                    b_next     = OperandB;
                    sgn_next   = (Op == OP_MADD) || (Op == OP_MSUB);
                    acc_next   = 1'b1;
                    sub_next   = (Op == OP_MSUB) || (Op == OP_MSUBU);
                    count_next = CW'(MUL_LATENCY);
                    state_next = S_MUL;
                end
`endif
                OP_DIV, OP_DIVU: begin
                    if (OperandB == '0) begin
                        // No iterations: report immediately, Hi/Lo untouched.
                        dbz_next   = 1'b1;
                        state_next = S_FIN;
                    end else begin
                        a_next     = abs_a;
                        b_next     = abs_b;
                        rem_next   = '0;
                        qneg_next  = div_signed && (OperandA[DW-1] ^ OperandB[DW-1]);
                        rneg_next  = div_signed && OperandA[DW-1];
                        count_next = '0;
                        state_next = S_DIV;
                    end
                end
                OP_MTHI: hi_next = OperandA;
                OP_MTLO: lo_next = OperandA;
                default: ;
            endcase
        end
    end

    always_ff @(negedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_reg <= S_IDLE;
            count_reg <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            rem_reg   <= '0;
            sgn_reg   <= 1'b0;
            qneg_reg  <= 1'b0;
            rneg_reg  <= 1'b0;
            dbz_reg   <= 1'b0;
`ifdef HILO_ACCUM_EN
            acc_reg   <= 1'b0;
            sub_reg   <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            rem_reg   <= rem_next;
            sgn_reg   <= sgn_next;
            qneg_reg  <= qneg_next;
            rneg_reg  <= rneg_next;
            dbz_reg   <= dbz_next;
`ifdef HILO_ACCUM_EN
            acc_reg   <= acc_next;
            sub_reg   <= sub_next;
`endif
        end
    end

    assign Done      = (state_reg == S_FIN);
    assign DivByZero = (state_reg == S_FIN) && dbz_reg;
    assign Hi        = hi_reg;
    assign Lo        = lo_reg;

endmodule
